aes_round_controller: RTL and testbench



---
 rtl/aes_round_controller_pkg.sv | 97 +++++++++
 rtl/aes_round_controller_if.sv | 32 +++
 rtl/aes_round_controller_datapath.sv | 22 ++
 rtl/aes_round_controller.sv | 95 +++++++++
 tb/tb_aes_round_controller.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_round_controller_pkg.sv
// Shared AES constants, FSM encodings, FIPS-197 vectors and the byte-level
// round primitives (SubBytes, ShiftRows, MixColumns) used by the datapath.
package aes_round_controller_pkg;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    // Controller FSM encodings
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    // 128-bit AES state, byte 0 in bits 0:7, column-major (FIPS-197 order)
    typedef logic [0:127] aes_block_t;

    // FIPS-197 reference vectors
    localparam aes_block_t TV_B_PT      = 128'h3243f6a8885a308d313198a2e0370734;
    localparam aes_block_t TV_B_KEY     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_block_t TV_B_AFT_E0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam aes_block_t TV_B_AFT_E1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam aes_block_t TV_B_CT      = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam aes_block_t TV_C1_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam aes_block_t TV_C1_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_block_t TV_C1_CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam aes_block_t TV_C3_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:255] TV_C3_KEY  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam aes_block_t TV_C3_CT     = 128'h8ea2b7ca516745bfeafc49904b496089;

    // Forward S-box, entry n at bits 8n:8n+7
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] idx;
        idx = {b, 3'b000};
        return SBOX_TABLE[idx +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_block_t sub_bytes(input aes_block_t s);
        aes_block_t o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sub_byte(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns; byte (r,c) lives at index 4c+r
    function automatic aes_block_t shift_rows(input aes_block_t s);
        aes_block_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_block_t mix_columns(input aes_block_t s);
        aes_block_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(4*c)   +: 8];
            a1 = s[8*(4*c+1) +: 8];
            a2 = s[8*(4*c+2) +: 8];
            a3 = s[8*(4*c+3) +: 8];
            o[8*(4*c)   +: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
            o[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
            o[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
            o[8*(4*c+3) +: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round_controller_if.sv
// Bus between the encryption wrapper / key store and the round controller.
//
// Handshake: start is a request level sampled only while the controller is
// idle (busy=0); there is no ready signal and a start seen while busy=1 is
// dropped. done is a single-cycle pulse marking stateOut valid; stateOut then
// holds until the next accepted block finishes. roundIndex addresses the key
// store, which must answer on roundKey combinationally in the same cycle.
interface aes_round_controller_if
    import aes_round_controller_pkg::*;
#(
    parameter int RW = 4
);
    logic            start;
    aes_block_t      stateIn;
    aes_block_t      roundKey;
    logic [RW-1:0]   roundIndex;
    logic            busy;
    logic            done;
    aes_block_t      stateOut;

    // Wrapper plus key store side
    modport master (
        output start, stateIn, roundKey,
        input  roundIndex, busy, done, stateOut
    );

    // Round controller side
    modport slave (
        input  start, stateIn, roundKey,
        output roundIndex, busy, done, stateOut
    );
endinterface

// File: rtl/aes_round_controller_datapath.sv
// Combinational AES round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey,
// with MixColumns bypassed for the last round.
module aes_round_controller_datapath
    import aes_round_controller_pkg::*;
(
    input  aes_block_t i_state_in,
    input  aes_block_t i_round_key,
    input  logic       i_last_round,
    output aes_block_t o_state_out
);
    aes_block_t w_sub;
    aes_block_t w_shift;
    aes_block_t w_mix;

    // One round transform; the final round skips the column mix
    always_comb begin
        w_sub       = sub_bytes(i_state_in);
        w_shift     = shift_rows(w_sub);
        w_mix       = mix_columns(w_shift);
        o_state_out = (i_last_round ? w_shift : w_mix) ^ i_round_key;
    end
endmodule

// File: rtl/aes_round_controller.sv
// Iterative AES encryption round sequencer: one round per clock on a single
// 128-bit state register, round keys fetched from an external store by index.
module aes_round_controller
    import aes_round_controller_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int RW = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    aes_round_controller_if.slave        bus,
    output logic [1:0]                   o_dbg_state
);

    if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256)) begin : g_bad_nr
        $error("aes_round_controller: NR=%0d must be 10, 12 or 14", NR);
    end
    if ((2 ** RW) <= NR) begin : g_bad_rw
        $error("aes_round_controller: RW=%0d too narrow for NR=%0d", RW, NR);
    end

    localparam logic [RW-1:0] IDX_ONE        = RW'(1);
    localparam logic [RW-1:0] IDX_LAST_ROUND = RW'(NR - 1);
    // With a single round the first edge would go straight to the final round
    localparam logic [1:0]    S_AFTER_START  = (NR == 1) ? S_FINAL : S_ROUND;

    logic [1:0]    r_state;
    aes_block_t    r_state_reg;
    aes_block_t    r_state_out;
    logic [RW-1:0] r_round_index;
    logic          r_busy;
    logic          r_done;

    aes_block_t    w_round_out;
    logic          w_last_round;

    assign w_last_round = (r_state == S_FINAL);

    aes_round_controller_datapath u_datapath (
        .i_state_in   (r_state_reg),
        .i_round_key  (bus.roundKey),
        .i_last_round (w_last_round),
        .o_state_out  (w_round_out)
    );

    // Round sequencing: key-0 whitening, NR-1 full rounds, one final round
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_state_reg   <= '0;
            r_state_out   <= '0;
            r_round_index <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state_reg   <= bus.stateIn ^ bus.roundKey;
                        r_round_index <= IDX_ONE;
                        r_busy        <= 1'b1;
                        r_state       <= S_AFTER_START;
                    end
                end
                S_ROUND: begin
                    r_state_reg   <= w_round_out;
                    r_round_index <= r_round_index + IDX_ONE;
                    if (r_round_index == IDX_LAST_ROUND) begin
                        r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    r_state_out   <= w_round_out;
                    r_done        <= 1'b1;
                    r_busy        <= 1'b0;
                    r_round_index <= '0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_busy        <= 1'b0;
                    r_round_index <= '0;
                end
            endcase
        end
    end

    assign bus.roundIndex = r_round_index;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.stateOut   = r_state_out;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_aes_round_controller.sv
// Directed FIPS-197 bench for aes_round_controller (NR=10 and NR=14 instances)
// with a key-expansion key-store model and a done-driven ciphertext scoreboard.
module tb_aes_round_controller;
    import aes_round_controller_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs and key stores ----------------
    aes_round_controller_if #(.RW(4)) bus10 ();
    aes_round_controller_if #(.RW(4)) bus14 ();
    logic [1:0] dbg10;
    logic [1:0] dbg14;

    logic [0:127] rk10 [0:15];
    logic [0:127] rk14 [0:15];

    assign bus10.roundKey = rk10[bus10.roundIndex];
    assign bus14.roundKey = rk14[bus14.roundIndex];

    aes_round_controller #(.NR(10), .RW(4)) dut10 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus10),
        .o_dbg_state (dbg10)
    );

    aes_round_controller #(.NR(14), .RW(4)) dut14 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus14),
        .o_dbg_state (dbg14)
    );

    // ---------------- scoreboard state ----------------
    logic [127:0] exp_q10[$];
    logic [127:0] exp_q14[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_done10 = 0;
    int n_done14 = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- key-store model (FIPS-197 key expansion) ----------------
    function automatic logic [7:0] rcon_next(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [0:127] expand_round_key(input logic [0:255] key, input int nk, input int r);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = key[32*i +: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = rcon_next(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic load_keys(input logic [0:255] key, input int nk, input bit sel14);
        logic [0:127] k;
        for (int r = 0; r < 16; r++) begin
            k = (r < 15) ? expand_round_key(key, nk, r) : '0;
            if (sel14) rk14[r] = k;
            else       rk10[r] = k;
        end
    endtask

    // ---------------- monitors: pop expected ciphertext on each done ----------------
    always @(negedge clk) begin
        if (bus10.done) begin
            n_done10++;
            if (exp_q10.size() == 0) begin
                n_checks++;
                $display("FAIL ct10_spurious_done: got done with stateOut %h, expected no done", bus10.stateOut);
            end else begin
                check("ct10", bus10.stateOut, exp_q10.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (bus14.done) begin
            n_done14++;
            if (exp_q14.size() == 0) begin
                n_checks++;
                $display("FAIL ct14_spurious_done: got done with stateOut %h, expected no done", bus14.stateOut);
            end else begin
                check("ct14", bus14.stateOut, exp_q14.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds start for one edge; stateIn is scrubbed afterwards since it must
    // not be re-read once the block is accepted.
    task automatic start10(input logic [0:127] pt);
        bus10.stateIn = pt;
        bus10.start   = 1'b1;
        @(posedge clk);
        #1;
        bus10.start   = 1'b0;
        bus10.stateIn = '0;
    endtask

    task automatic wait_done10(input int cycles_in, input int exp_lat, input string name);
        int cycles;
        cycles = cycles_in;
        while (!bus10.done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_int(name, cycles, exp_lat);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int cycles;
    int busy_cycles;
    int hold_err;
    int n0;

    initial begin
        reset         = 1'b1;
        bus10.start   = 1'b0;
        bus10.stateIn = '0;
        bus14.start   = 1'b0;
        bus14.stateIn = '0;
        for (int r = 0; r < 16; r++) begin
            rk10[r] = '0;
            rk14[r] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check_int("rst10_busy", int'(bus10.busy), 0);
        check_int("rst10_done", int'(bus10.done), 0);
        check_int("rst10_idx", int'(bus10.roundIndex), 0);
        check("rst10_stateout", bus10.stateOut, 128'h0);
        check_int("rst10_fsm", int'(dbg10), int'(S_IDLE));
        check_int("rst14_busy", int'(bus14.busy), 0);
        check_int("rst14_done", int'(bus14.done), 0);
        check_int("rst14_idx", int'(bus14.roundIndex), 0);
        check("rst14_stateout", bus14.stateOut, 128'h0);
        check_int("rst14_fsm", int'(dbg14), int'(S_IDLE));
        idle(2);

        // App. B: intermediate states and latency
        load_keys({TV_B_KEY, 128'h0}, 4, 1'b0);
        exp_q10.push_back(TV_B_CT);
        start10(TV_B_PT);
        check("appb_after_e0", dut10.r_state_reg, TV_B_AFT_E0);
        idle(1);
        check("appb_after_e1", dut10.r_state_reg, TV_B_AFT_E1);
        wait_done10(2, 11, "appb_latency");
        idle(2);

        // App. C.1: roundIndex sequence and busy width
        load_keys({TV_C1_KEY, 128'h0}, 4, 1'b0);
        exp_q10.push_back(TV_C1_CT);
        check_int("c1_idx_0", int'(bus10.roundIndex), 0);
        start10(TV_C1_PT);
        busy_cycles = 0;
        for (int k = 1; k <= 11; k++) begin
            check_int($sformatf("c1_idx_%0d", k), int'(bus10.roundIndex), (k <= 10) ? k : 0);
            if (bus10.busy) busy_cycles++;
            if (k < 11) idle(1);
        end
        check_int("c1_done_cycle", int'(bus10.done), 1);
        check_int("c1_busy_cycles", busy_cycles, 10);
        idle(2);

        // Start while busy is ignored
        load_keys({TV_B_KEY, 128'h0}, 4, 1'b0);
        exp_q10.push_back(TV_B_CT);
        n0 = n_done10;
        start10(TV_B_PT);
        idle(2);
        start10(TV_C1_PT);
        wait_done10(4, 11, "ign_latency");
        idle(15);
        check_int("ign_done_count", n_done10 - n0, 1);
        check("ign_ct_hold", bus10.stateOut, TV_B_CT);

        // Back-to-back: second start in the done cycle
        exp_q10.push_back(TV_B_CT);
        start10(TV_B_PT);
        wait_done10(1, 11, "b2b_first_latency");
        load_keys({TV_C1_KEY, 128'h0}, 4, 1'b0);
        exp_q10.push_back(TV_C1_CT);
        start10(TV_C1_PT);
        cycles   = 1;
        hold_err = 0;
        while (!bus10.done && cycles < 40) begin
            if (bus10.stateOut !== TV_B_CT) hold_err++;
            idle(1);
            cycles++;
        end
        check_int("b2b_second_latency", cycles, 11);
        check_int("b2b_hold_errors", hold_err, 0);
        idle(2);

        // Reset during round 5 aborts the block
        load_keys({TV_B_KEY, 128'h0}, 4, 1'b0);
        start10(TV_B_PT);
        cycles = 1;
        while (int'(bus10.roundIndex) != 5 && cycles < 20) begin
            idle(1);
            cycles++;
        end
        check_int("midrst_reach_round5", int'(bus10.roundIndex), 5);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_int("midrst_busy", int'(bus10.busy), 0);
        check_int("midrst_done", int'(bus10.done), 0);
        check_int("midrst_idx", int'(bus10.roundIndex), 0);
        check("midrst_stateout", bus10.stateOut, 128'h0);
        check_int("midrst_fsm", int'(dbg10), int'(S_IDLE));
        exp_q10.push_back(TV_B_CT);
        start10(TV_B_PT);
        wait_done10(1, 11, "midrst_rerun_latency");
        idle(2);

        // NR=14 with App. C.3
        load_keys(TV_C3_KEY, 8, 1'b1);
        exp_q14.push_back(TV_C3_CT);
        bus14.stateIn = TV_C3_PT;
        bus14.start   = 1'b1;
        idle(1);
        bus14.start   = 1'b0;
        bus14.stateIn = '0;
        cycles = 1;
        while (!bus14.done && cycles < 40) begin
            idle(1);
            cycles++;
        end
        check_int("c3_latency", cycles, 15);
        idle(3);

        check_int("q10_drained", exp_q10.size(), 0);
        check_int("q14_drained", exp_q14.size(), 0);
        check_int("done14_count", n_done14, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
